// File: rtl/aes_pkg.sv
// Shared AES front-end definitions: key-size encodings, mode encodings and loader state set.
package aes_pkg;

  localparam logic ENCRYPT = 1'b0;
  localparam logic DECRYPT = 1'b1;

  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;

  typedef enum logic [1:0] {IDLE, KEY, DATA, HOLD} loaderState_e;

  // Key length in bytes; the illegal encoding never gets latched, so it maps to 16.
  function automatic logic [5:0] key_bytes(input logic [1:0] keyType);
    case (keyType)
      MODE_192: return 6'd24;
      MODE_256: return 6'd32;
      default:  return 6'd16;
    endcase
  endfunction

endpackage

// File: rtl/aes_block_loader.sv
// Byte-serial loader: packs key bytes then 16 block bytes into left-justified registers
// and offers the finished frame to the AES cores over a valid/ready handshake.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter bit          CHECK_LAST  = 1'b1,
  parameter int unsigned BLOCK_BYTES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   keyType,
  input  logic         mode,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_abort,
  output logic         in_ready,
  output logic [0:255] key_out,
  output logic [0:127] block_out,
  output logic [1:0]   out_keyType,
  output logic         out_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         cfg_err,
  output logic         frame_err
);

  loaderState_e state;
  logic [4:0]   byteCnt;
  logic [5:0]   keyLen;
  logic         xfer;
  logic         lastByte;
  logic         lastErr;

  always_comb begin
    keyLen   = key_bytes(out_keyType);
    xfer     = in_valid && in_ready && !in_abort;
    lastByte = (state == DATA) && (byteCnt == 5'(BLOCK_BYTES - 1));
    lastErr  = CHECK_LAST && (in_last != lastByte);
  end

  assign cfg_err  = (state == IDLE) && (keyType == 2'b11);
  assign in_ready = !reset && (((state == IDLE) && (keyType != 2'b11)) ||
                               (state == KEY) || (state == DATA));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      byteCnt     <= '0;
      key_out     <= '0;
      block_out   <= '0;
      out_keyType <= 2'b00;
      out_mode    <= 1'b0;
      out_valid   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (in_abort) begin
        // Abort wins over a same-cycle transfer; the byte is dropped.
        if (state != IDLE) begin
          state     <= IDLE;
          byteCnt   <= '0;
          out_valid <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (xfer) begin
              if (lastErr) begin
                frame_err <= 1'b1;
              end else begin
                out_keyType <= keyType;
                out_mode    <= mode;
                key_out     <= {in_byte, 248'd0};
                block_out   <= '0;
                byteCnt     <= 5'd1;
                state       <= KEY;
              end
            end
          end
          KEY: begin
            if (xfer) begin
              if (lastErr) begin
                frame_err <= 1'b1;
                byteCnt   <= '0;
                state     <= IDLE;
              end else begin
                key_out[{byteCnt, 3'b000} +: 8] <= in_byte;
                if (byteCnt == 5'(keyLen - 6'd1)) begin
                  byteCnt <= '0;
                  state   <= DATA;
                end else begin
                  byteCnt <= byteCnt + 5'd1;
                end
              end
            end
          end
          DATA: begin
            if (xfer) begin
              if (lastErr) begin
                frame_err <= 1'b1;
                byteCnt   <= '0;
                state     <= IDLE;
              end else begin
                block_out[{byteCnt[3:0], 3'b000} +: 8] <= in_byte;
                if (lastByte) begin
                  out_valid <= 1'b1;
                  state     <= HOLD;
                end else begin
                  byteCnt <= byteCnt + 5'd1;
                end
              end
            end
          end
          HOLD: begin
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              byteCnt   <= '0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
Byte-serial input front end for the AES datapath. It receives a frame over a valid/ready byte stream: the key bytes come first, then 16 plaintext or ciphertext bytes. It packs these into a left-justified key register and a 128-bit block register, then presents them, with the latched keyType and mode, to the encrypt/decrypt cores through a valid/ready handshake. It sits between the board or host interface and the keySchedule/aesEncrypt/Decryption instances, as the input counterpart of the result/seven-segment output path.

Parameters:
CHECK_LAST, 1, when 1 the in_last flag must match the final byte of the frame; when 0 in_last is ignored.
BLOCK_BYTES, 16, data bytes per frame; fixed at 16 for AES and not to be overridden.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
keyType  input  2  00=128, 01=192, 10=256, 11=illegal; sampled only when the first byte of a frame is accepted.
mode  input  1  0=encrypt, 1=decrypt; sampled together with keyType.
in_byte  input  8  stream byte.
in_valid  input  1  in_byte is valid.
in_last  input  1  sender marks the final byte of the frame.
in_abort  input  1  synchronous frame abort.
in_ready  output  1  loader accepts a byte this cycle.
key_out  output  256  key, bit-indexed [0:255]; byte i occupies bits [8i +: 8]; unused tail bytes are 0.
block_out  output  128  block, bit-indexed [0:127]; byte j occupies bits [8j +: 8].
out_keyType  output  2  latched keyType.
out_mode  output  1  latched mode.
out_valid  output  1  frame complete; outputs held stable.
out_ready  input  1  the core accepts the frame.
cfg_err  output  1  combinational; high in IDLE while keyType==11.
frame_err  output  1  one-cycle pulse on an in_last mismatch.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, byte_cnt=0, key_out=0, block_out=0, out_keyType=00, out_mode=0, out_valid=0, frame_err=0.
- Byte handshake: a byte transfers on the clk edge where in_valid && in_ready.
- in_ready is combinational: 1 in IDLE (when keyType!=11), KEY and DATA; 0 in HOLD and 0 while reset is high.
- Key length L: 16, 24 or 32 bytes for keyType 00, 01, 10.
- IDLE:
  - On a transfer, latch keyType and mode, clear key_out and block_out, and write in_byte to key byte 0.
  - Set byte_cnt=1 and go to KEY.
- KEY:
  - Each transfer writes key byte byte_cnt and increments byte_cnt.
  - On the transfer where byte_cnt==L-1, set byte_cnt=0 and go to DATA.
- DATA:
  - Each transfer writes block byte byte_cnt.
  - On the transfer where byte_cnt==15, go to HOLD and set out_valid=1 on the same edge.
  - Latency: out_valid is high the cycle after the final byte handshake.
- HOLD:
  - Outputs are frozen.
  - On out_valid && out_ready: out_valid=0, state=IDLE, byte_cnt=0. key_out and block_out keep their values until the next frame starts.
- in_last check (CHECK_LAST=1):
  - in_last=1 on any transfer other than frame byte L+15, or in_last=0 on byte L+15, triggers an error.
  - On error: frame_err pulses for 1 cycle, the byte is discarded, state=IDLE, byte_cnt=0, and out_valid stays 0.
- keyType/mode changes mid-frame are ignored; the latched values are used.
- in_abort has priority over any transfer in the same cycle; that byte is dropped.
  - In KEY/DATA: go to IDLE, byte_cnt=0.
  - In HOLD: out_valid=0 and go to IDLE.
  - In IDLE: no effect.
- Back-to-back frames: IDLE accepts a new first byte the cycle after HOLD exits; there is no bubble beyond that one cycle.
- byte_cnt is 5 bits and never exceeds 31; no wrap is possible given the transitions above.
- Reset asserted mid-frame returns immediately to the reset values; the partial frame is lost.

Decomposition:
- Shared package aes_pkg holds:
  - localparams ENCRYPT=0, DECRYPT=1, MODE_128=00, MODE_192=01, MODE_256=10;
  - function key_bytes(keyType) returning 16/24/32;
  - the state encoding IDLE/KEY/DATA/HOLD.
- No sub-module. Byte placement is a single indexed write into the key and block registers, inline with the FSM.

Test Plan:
1. keyType=00, mode=0; stream 2b7e151628aed2a6abf7158809cf4f3c then 6bc1bee22e409f96e93d7e117393172a, in_last on byte 32, out_ready=1 -> out_valid for exactly 1 cycle, beginning one cycle after byte 32; key_out=2b7e…4f3c followed by 128 zero bits; block_out=6bc1…172a; out_keyType=00.
2. keyType=10; stream the 32-byte key 603deb10…0914dff4 plus the plaintext, with random in_valid gaps and out_ready held 0 for 5 cycles -> in_ready=0 and all outputs stable during HOLD; handshake completes on the cycle out_ready rises; state returns to IDLE.
3. keyType=01; in_last asserted on byte 39 (expected on byte 40) -> frame_err pulses once, out_valid never asserts; a following correct 40-byte frame loads key 8e73b0f7…522c6b7b.
4. in_abort together with in_valid on byte 20 of a 128-bit frame -> byte dropped, IDLE; the next frame's first byte lands at key byte 0.
5. keyType=11 in IDLE -> cfg_err=1, in_ready=0, no bytes accepted; switch to 00 -> cfg_err=0, in_ready=1.
6. Assert reset during DATA byte 5 -> out_valid=0, key_out=0, block_out=0 immediately; after release the first byte goes to key byte 0.
